// File: rtl/i2c_request_arbiter.sv
// Round-robin arbiter sharing one i2c_controller write port among NUM_REQ requesters.
// Optional per-phase handshake timeout abort is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [NUM_REQ-1:0]   req_in,
  input  logic [7*NUM_REQ-1:0] addr_in,
  input  logic [8*NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic [NUM_REQ-1:0]   done_out,
  output logic [NUM_REQ-1:0]   err_out,
  output logic                 busy_out,
  output logic                 start_out,
  output logic [6:0]           addr_out,
  output logic [7:0]           data_out,
  input  logic                 ready_in
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               ready_meta_q, ready_meta_d;
  logic               rdy_s_q, rdy_s_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               start_q, start_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [IW-1:0]      last_q, last_d;

  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic [6:0]         addr_sel;
  logic [7:0]         data_sel;
  logic [NUM_REQ-1:0] owner_oh;
  logic               tmo;

  // First requester at or after last+1, wrapping; the last owner ends up lowest priority.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && req_in[IW'(j)]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        addr_sel = addr_in[7*i +: 7];
        data_sel = data_in[8*i +: 8];
      end
    end
  end

  assign owner_oh = NUM_REQ'(1) << last_q;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  assign tmo     = ((state_q == S_LAUNCH) || (state_q == S_WAIT)) &&
                   (cnt_q >= 32'(TIMEOUT_CYCLES - 1));
  assign err_out = err_q;
`else
  assign tmo     = 1'b0;
  assign err_out = '0;
`endif

  always_comb begin
    ready_meta_d = ready_in;
    rdy_s_d      = ready_meta_q;
    state_d      = state_q;
    grant_d      = grant_q;
    done_d       = '0;
    start_d      = start_q;
    addr_d       = addr_q;
    data_d       = data_q;
    last_d       = last_q;

    case (state_q)
      S_IDLE: begin
        if (rdy_s_q && pick_vld) begin
          state_d = S_LAUNCH;
          grant_d = NUM_REQ'(1) << pick_idx;
          addr_d  = addr_sel;
          data_d  = data_sel;
          last_d  = pick_idx;
          start_d = 1'b1;
        end
      end
      // Ready falling is the controller's acknowledgement of start.
      S_LAUNCH: begin
        if (!rdy_s_q) begin
          state_d = S_WAIT;
          start_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (rdy_s_q) begin
          state_d = S_DONE;
          done_d  = owner_oh;
          grant_d = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (tmo) begin
      state_d = S_IDLE;
      start_d = 1'b0;
      grant_d = '0;
      done_d  = '0;
    end

`ifdef I2C_ARB_TIMEOUT_EN
    err_d = tmo ? owner_oh : '0;
    cnt_d = ((state_d != state_q) || !((state_q == S_LAUNCH) || (state_q == S_WAIT)))
            ? '0 : cnt_q + 32'd1;
`endif
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= S_IDLE;
      ready_meta_q <= 1'b0;
      rdy_s_q      <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      start_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      last_q       <= IW'(NUM_REQ - 1);
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ready_meta_q <= ready_meta_d;
      rdy_s_q      <= rdy_s_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      start_q      <= start_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      last_q       <= last_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign grant_out = grant_q;
  assign done_out  = done_q;
  assign start_out = start_q;
  assign addr_out  = addr_q;
  assign data_out  = data_q;
  assign busy_out  = (state_q != S_IDLE);

endmodule
